// File: rtl/axis_fan_out_pkg.sv
// Shared AXI-stream routing definitions: route FSM states and index-to-one-hot decode.
// Both the fan-out and the fan-in stages use these definitions.
package axis_fan_out_pkg;

  localparam int unsigned MAX_CHANNELS = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ROUTE,
    ST_DROP
  } route_state_t;

  // Indices outside the supported channel range decode to all-zero.
  function automatic logic [MAX_CHANNELS-1:0] bin_to_onehot(input logic [31:0] idx);
    return (idx < MAX_CHANNELS) ? (32'd1 << idx[4:0]) : '0;
  endfunction

endpackage

// File: rtl/axis_fan_out_skid_buf.sv
// Two-entry skid buffer. in_ready is a register, so it has no combinational path from out_ready.
module axis_skid_buf #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             skid_valid;
  logic [WIDTH-1:0] skid_data;
  logic             push;
  logic             pop;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // A push can only happen while the skid entry is empty, because in_ready tracks ~skid_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      in_ready   <= 1'b0;
    end else if (pop || !out_valid) begin
      in_ready <= 1'b1;
      if (skid_valid) begin
        out_data   <= skid_data;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else if (push) begin
        out_data  <= in_data;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (push) begin
      skid_data  <= in_data;
      skid_valid <= 1'b1;
      in_ready   <= 1'b0;
    end else begin
      in_ready <= ~skid_valid;
    end
  end

endmodule

// File: rtl/axis_fan_out.sv
// AXI-stream fan-out: steers each beat, or each packet, to the channel selected by tuser.
// Beats addressed to a nonexistent channel are consumed and counted in a saturating counter.
module axis_fan_out
  import axis_fan_out_pkg::*;
#(
  parameter int unsigned NUM_FANOUT     = 6,
  parameter int unsigned DATA_WIDTH     = 256,
  parameter int unsigned USE_AXIS_TLAST = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tlast,
  input  logic [NUM_FANOUT-1:0] s_axis_tuser,
  output logic [NUM_FANOUT-1:0] m_axis_tvalid,
  input  logic [NUM_FANOUT-1:0] m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic [15:0]           drop_count
);

  localparam int unsigned PW = DATA_WIDTH + 1 + NUM_FANOUT;
  localparam logic [31:0] CH_MASK =
    (NUM_FANOUT >= 32) ? '1 : 32'((64'd1 << NUM_FANOUT) - 64'd1);

  route_state_t          state;
  logic [NUM_FANOUT-1:0] dest_q;
  logic [31:0]           oh_full;
  logic                  idx_valid;
  logic                  fwd;
  logic [NUM_FANOUT-1:0] fwd_oh;
  logic                  accept;

  logic                  head_valid;
  logic                  head_ready;
  logic [PW-1:0]         head_data;
  logic [NUM_FANOUT-1:0] head_dest;

  assign oh_full   = bin_to_onehot(32'(s_axis_tuser));
  assign idx_valid = |(oh_full & CH_MASK);
  assign accept    = s_axis_tvalid & s_axis_tready;

  always_comb begin
    fwd    = idx_valid;
    fwd_oh = oh_full[NUM_FANOUT-1:0];
    if (state == ST_ROUTE) begin
      fwd    = 1'b1;
      fwd_oh = dest_q;
    end else if (state == ST_DROP) begin
      fwd = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      dest_q     <= '0;
      drop_count <= '0;
    end else if (accept) begin
      if (!fwd && drop_count != '1)
        drop_count <= drop_count + 16'd1;
      case (state)
        ST_IDLE: begin
          if (USE_AXIS_TLAST != 0 && !s_axis_tlast) begin
            state  <= idx_valid ? ST_ROUTE : ST_DROP;
            dest_q <= fwd_oh;
          end
        end
        ST_ROUTE, ST_DROP: begin
          if (s_axis_tlast)
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  axis_skid_buf #(
    .WIDTH(PW)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .in_valid (s_axis_tvalid & fwd),
    .in_ready (s_axis_tready),
    .in_data  ({s_axis_tdata, s_axis_tlast, fwd_oh}),
    .out_valid(head_valid),
    .out_ready(head_ready),
    .out_data (head_data)
  );

  assign head_dest     = head_data[NUM_FANOUT-1:0];
  assign head_ready    = |(m_axis_tready & head_dest);
  assign m_axis_tvalid = head_valid ? head_dest : '0;
  assign m_axis_tlast  = head_data[NUM_FANOUT];
  assign m_axis_tdata  = head_data[PW-1:NUM_FANOUT+1];

endmodule
